systolic_drain: RTL and testbench

- Sequences readout of the systolic PE accumulators once a matmul tile is finished.
- Sits directly downstream of the systolic array. Consumes its per-PE accumulator outputs; drives its per-row/per-column Clear inputs.
- Waits a settle window for in-flight wavefronts to finish, then streams one accumulator row per beat over a valid/ready interface. Clears each row once that row has been accepted.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/systolic_drain.sv | 188 ++++++++++++++++++
 tb/tb_systolic_drain.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the systolic array drain logic.
// Contents:
//   drain_state_e : drain sequencer states
//   row_idx_w()   : width of a row index, never narrower than one bit
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        LOAD   = 3'd2,
        SEND   = 3'd3,
        CLEAR  = 3'd4,
        DONE   = 3'd5
    } drain_state_e;

    function automatic int unsigned row_idx_w(input int unsigned rows);
        return (rows > 1) ? int'($clog2(rows)) : 1;
    endfunction

endpackage

// File: rtl/systolic_drain.sv
// Sequences readout of the systolic PE accumulators once a tile is finished.
// After Start it waits SETTLE_CYCLES for in-flight wavefronts, then streams
// one accumulator row per beat over valid/ready and clears each row once it
// has been accepted.
// Ports:
//   i_clock        : clock, all state on the rising edge
//   i_reset_n      : synchronous active-low reset
//   i_start        : tile complete, sampled only in IDLE
//   i_accs_in      : flattened PE accumulators, row r col c at ((r*COLS+c)*N)
//   o_clear_row    : one-hot row clear to the array
//   o_clear_column : column clear to the array (all-ones while clearing)
//   o_row_data     : row payload, column c at (c*N)
//   o_row_index    : index of the row in o_row_data
//   o_row_valid    : payload valid
//   i_row_ready    : consumer accepts the payload
//   o_row_last     : payload is the final row
//   o_busy         : high in every state except IDLE
//   o_done         : one-cycle pulse after the last row was cleared
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int unsigned ARRAY_OUTPUTS_N = 32,
    parameter int unsigned ARRAY_ROWS      = 64,
    parameter int unsigned ARRAY_COLUMNS   = 64,
    parameter int unsigned SETTLE_CYCLES   = ARRAY_ROWS + ARRAY_COLUMNS
) (
    input  logic                                                  i_clock,
    input  logic                                                  i_reset_n,
    input  logic                                                  i_start,
    input  logic [ARRAY_ROWS*ARRAY_COLUMNS*ARRAY_OUTPUTS_N-1:0]   i_accs_in,
    output logic [ARRAY_ROWS-1:0]                                 o_clear_row,
    output logic [ARRAY_COLUMNS-1:0]                              o_clear_column,
    output logic [ARRAY_COLUMNS*ARRAY_OUTPUTS_N-1:0]              o_row_data,
    output logic [row_idx_w(ARRAY_ROWS)-1:0]                      o_row_index,
    output logic                                                  o_row_valid,
    input  logic                                                  i_row_ready,
    output logic                                                  o_row_last,
    output logic                                                  o_busy,
    output logic                                                  o_done
);

    localparam int unsigned ROW_IDX_W = row_idx_w(ARRAY_ROWS);
    localparam int unsigned ROW_W     = ARRAY_COLUMNS * ARRAY_OUTPUTS_N;
    localparam int unsigned CNT_W     = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ARRAY_ROWS - 1);

    drain_state_e                 r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic [ROW_IDX_W-1:0]         r_row_ptr;
    logic [ROW_W-1:0]             r_row_data;
    logic [ROW_IDX_W-1:0]         r_row_index;
    logic                         r_row_valid;
    logic                         r_row_last;
    logic [ARRAY_ROWS-1:0]        r_clear_row;
    logic [ARRAY_COLUMNS-1:0]     r_clear_column;
    logic                         r_busy;
    logic                         r_done;

    drain_state_e                 w_state;
    logic [CNT_W-1:0]             w_cnt;
    logic [ROW_IDX_W-1:0]         w_row_ptr;
    logic [ROW_W-1:0]             w_row_data;
    logic [ROW_IDX_W-1:0]         w_row_index;
    logic                         w_row_valid;
    logic                         w_row_last;
    logic [ARRAY_ROWS-1:0]        w_clear_row;
    logic [ARRAY_COLUMNS-1:0]     w_clear_column;
    logic                         w_busy;
    logic                         w_done;
    logic [ROW_W-1:0]             w_row_sel;

    // Row mux: accumulator row addressed by the row pointer
    always_comb begin
        w_row_sel = '0;
        for (int r = 0; r < int'(ARRAY_ROWS); r++) begin
            if (r_row_ptr == ROW_IDX_W'(r)) begin
                w_row_sel = i_accs_in[r*ROW_W +: ROW_W];
            end
        end
    end

    // Next-state and next-output logic; clears and Done are single-cycle pulses
    always_comb begin
        w_state        = r_state;
        w_cnt          = r_cnt;
        w_row_ptr      = r_row_ptr;
        w_row_data     = r_row_data;
        w_row_index    = r_row_index;
        w_row_valid    = r_row_valid;
        w_row_last     = r_row_last;
        w_clear_row    = '0;
        w_clear_column = '0;
        w_busy         = r_busy;
        w_done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_row_ptr = '0;
                    w_busy    = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        w_state = LOAD;
                    end else begin
                        w_state = SETTLE;
                        w_cnt   = CNT_W'(SETTLE_CYCLES);
                    end
                end
            end
            SETTLE: begin
                // Counter holds the cycles remaining including this one
                w_cnt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state = LOAD;
                end
            end
            LOAD: begin
                w_row_data  = w_row_sel;
                w_row_index = r_row_ptr;
                w_row_last  = (r_row_ptr == LAST_ROW);
                w_row_valid = 1'b1;
                w_state     = SEND;
            end
            SEND: begin
                if (i_row_ready) begin
                    w_row_valid    = 1'b0;
                    w_clear_row    = ARRAY_ROWS'(1) << r_row_ptr;
                    w_clear_column = '1;
                    w_state        = CLEAR;
                end
            end
            CLEAR: begin
                if (r_row_ptr == LAST_ROW) begin
                    w_done  = 1'b1;
                    w_state = DONE;
                end else begin
                    w_row_ptr = r_row_ptr + ROW_IDX_W'(1);
                    w_state   = LOAD;
                end
            end
            DONE: begin
                w_busy  = 1'b0;
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_row_ptr      <= '0;
            r_row_data     <= '0;
            r_row_index    <= '0;
            r_row_valid    <= 1'b0;
            r_row_last     <= 1'b0;
            r_clear_row    <= '0;
            r_clear_column <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_cnt          <= w_cnt;
            r_row_ptr      <= w_row_ptr;
            r_row_data     <= w_row_data;
            r_row_index    <= w_row_index;
            r_row_valid    <= w_row_valid;
            r_row_last     <= w_row_last;
            r_clear_row    <= w_clear_row;
            r_clear_column <= w_clear_column;
            r_busy         <= w_busy;
            r_done         <= w_done;
        end
    end

    assign o_clear_row    = r_clear_row;
    assign o_clear_column = r_clear_column;
    assign o_row_data     = r_row_data;
    assign o_row_index    = r_row_index;
    assign o_row_valid    = r_row_valid;
    assign o_row_last     = r_row_last;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: a 4x4 array with modelled PE accumulators and
// clears, plus a 1-row, zero-settle instance. Expected payloads are queued
// when Start is issued; a negedge monitor checks every presented payload and
// the clear pulse following each accepted one.
module tb_systolic_drain;
    import systolic_pkg::*;

    localparam int unsigned N  = 32;
    localparam int unsigned R  = 4;
    localparam int unsigned C  = 4;
    localparam int unsigned S  = 3;
    localparam int unsigned RW = C * N;

    typedef struct packed {
        logic [RW-1:0] data;
        logic [1:0]    idx;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, start, ready, start_b, reload;
    logic [R*C*N-1:0] accs;
    logic [R-1:0]   clr_row;
    logic [C-1:0]   clr_col;
    logic [RW-1:0]  row_data;
    logic [1:0]     row_idx;
    logic           valid, last, busy, done;

    logic [RW-1:0]  accs_b;
    logic [0:0]     clr_row_b;
    logic [C-1:0]   clr_col_b;
    logic [RW-1:0]  row_data_b;
    logic [0:0]     row_idx_b;
    logic           valid_b, last_b, busy_b, done_b;

    logic [N-1:0]   pe [R][C];
    int             n_checks = 0;
    int             n_fail = 0;
    int             n_payloads = 0;
    exp_t           q[$];
    logic           mon_en = 1'b0;
    logic [R-1:0]   exp_clr_row = '0;
    logic           exp_clr_on = 1'b0;

    systolic_drain #(
        .ARRAY_OUTPUTS_N(N), .ARRAY_ROWS(R), .ARRAY_COLUMNS(C), .SETTLE_CYCLES(S)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_accs_in(accs),
        .o_clear_row(clr_row), .o_clear_column(clr_col), .o_row_data(row_data),
        .o_row_index(row_idx), .o_row_valid(valid), .i_row_ready(ready),
        .o_row_last(last), .o_busy(busy), .o_done(done)
    );

    systolic_drain #(
        .ARRAY_OUTPUTS_N(N), .ARRAY_ROWS(1), .ARRAY_COLUMNS(C), .SETTLE_CYCLES(0)
    ) dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(start_b), .i_accs_in(accs_b),
        .o_clear_row(clr_row_b), .o_clear_column(clr_col_b), .o_row_data(row_data_b),
        .o_row_index(row_idx_b), .o_row_valid(valid_b), .i_row_ready(1'b1),
        .o_row_last(last_b), .o_busy(busy_b), .o_done(done_b)
    );

    assign accs_b = {32'd103, 32'd102, 32'd101, 32'd100};

    // PE accumulator model: reload to 16*r+c, or zero where row and column clear meet
    always @(posedge clk) begin
        for (int r = 0; r < int'(R); r++) begin
            for (int c = 0; c < int'(C); c++) begin
                if (reload) pe[r][c] <= N'(16 * r + c);
                else if (clr_row[r] && clr_col[c]) pe[r][c] <= '0;
            end
        end
    end

    always @* begin
        accs = '0;
        for (int r = 0; r < int'(R); r++)
            for (int c = 0; c < int'(C); c++)
                accs[(r*C+c)*N +: N] = pe[r][c];
    end

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_row(input int base);
        logic [RW-1:0] v;
        v = '0;
        for (int c = 0; c < int'(C); c++) v[c*N +: N] = N'(base + c);
        return v;
    endfunction

    task automatic push_row(input logic [RW-1:0] d, input int r);
        exp_t e;
        e.data = d;
        e.idx  = 2'(r);
        e.last = (r == int'(R) - 1);
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 50) begin
            tick(1);
            k++;
        end
    endtask

    function automatic logic [N-1:0] pe_or();
        logic [N-1:0] v;
        v = '0;
        for (int r = 0; r < int'(R); r++)
            for (int c = 0; c < int'(C); c++) v = v | pe[r][c];
        return v;
    endfunction

    // Scoreboard monitor: payload vs queue head, then the clear that must follow acceptance
    always @(negedge clk) begin
        if (mon_en) begin
            chk("clear_row", RW'(clr_row), RW'(exp_clr_row));
            chk("clear_column", RW'(clr_col), exp_clr_on ? RW'({C{1'b1}}) : RW'(0));
            exp_clr_row = '0;
            exp_clr_on  = 1'b0;
            if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_payload: got index %0d expected none", row_idx);
                end else begin
                    chk("row_data", row_data, q[0].data);
                    chk("row_index", RW'(row_idx), RW'(q[0].idx));
                    chk("row_last", RW'(last), RW'(q[0].last));
                    if (ready) begin
                        exp_clr_row = R'(1) << q[0].idx;
                        exp_clr_on  = 1'b1;
                        void'(q.pop_front());
                        n_payloads++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p0;
        rst_n = 1'b0; start = 1'b0; ready = 1'b1; start_b = 1'b0; reload = 1'b1;

        // Reset with stray Row_Ready held high
        tick(2);
        rst_n = 1'b1; reload = 1'b0;
        chk("rst_valid", RW'(valid), RW'(0));
        chk("rst_busy", RW'(busy), RW'(0));
        chk("rst_data", row_data, '0);
        tick(3);
        chk("idle_valid", RW'(valid), RW'(0));
        chk("idle_busy", RW'(busy), RW'(0));
        chk("idle_done", RW'(done), RW'(0));
        chk("idle_index", RW'(row_idx), RW'(0));
        chk("idle_last", RW'(last), RW'(0));
        chk("idle_clr", RW'({clr_row, clr_col}), RW'(0));
        chk("idle_b", RW'({valid_b, busy_b, done_b, clr_row_b}), RW'(0));
        mon_en = 1'b1;

        // Full drain with Row_Ready high: 3 cycles per row
        for (int r = 0; r < int'(R); r++) push_row(mk_row(16 * r), r);
        start = 1'b1; tick(1); start = 1'b0;          // after edge E
        chk("t2_busy_rise", RW'(busy), RW'(1));
        chk("t2_valid_E", RW'(valid), RW'(0));
        tick(3);                                      // E+3
        chk("t2_valid_E3", RW'(valid), RW'(0));
        tick(1);                                      // E+4
        chk("t2_valid_E4", RW'(valid), RW'(1));
        tick(10);                                     // E+14
        chk("t2_done_E14", RW'(done), RW'(0));
        tick(1);                                      // E+15
        chk("t2_done_E15", RW'(done), RW'(1));
        chk("t2_busy_E15", RW'(busy), RW'(1));
        tick(1);                                      // E+16
        chk("t2_done_E16", RW'(done), RW'(0));
        chk("t2_busy_E16", RW'(busy), RW'(0));
        chk("t2_queue_empty", RW'(q.size()), RW'(0));
        chk("t2_pe_cleared", RW'(pe_or()), RW'(0));

        // Back-pressure on row 1, Start re-pulsed in SEND and in DONE
        reload = 1'b1; tick(1); reload = 1'b0;
        p0 = n_payloads;
        for (int r = 0; r < int'(R); r++) push_row(mk_row(16 * r), r);
        start = 1'b1; tick(1); start = 1'b0;          // E
        tick(5); ready = 1'b0;                        // E+5, row 0 accepted
        tick(2);                                      // E+7
        chk("t3_valid_row1", RW'(valid), RW'(1));
        chk("t3_index_row1", RW'(row_idx), RW'(1));
        tick(1); start = 1'b1; tick(1); start = 1'b0; // E+9
        tick(3);                                      // E+12
        chk("t3_valid_stall", RW'(valid), RW'(1));
        chk("t3_pe_row1_held", RW'(pe[1][2]), RW'(18));
        ready = 1'b1; tick(1);                        // E+13
        chk("t3_clr_row", RW'(clr_row), RW'(4'b0010));
        chk("t3_valid_drop", RW'(valid), RW'(0));
        wait_done(k);
        chk("t3_done_cycles", RW'(k), RW'(7));
        start = 1'b1; tick(1); start = 1'b0;          // Start sampled in DONE
        chk("t3_busy_after_done", RW'(busy), RW'(0));
        chk("t3_done_pulse", RW'(done), RW'(0));
        tick(4);
        chk("t3_no_restart", RW'({busy, valid}), RW'(0));
        chk("t3_payloads", RW'(n_payloads - p0), RW'(4));
        chk("t3_queue_empty", RW'(q.size()), RW'(0));

        // Reset while row 2 is waiting in SEND
        reload = 1'b1; tick(1); reload = 1'b0;
        for (int r = 0; r < int'(R); r++) push_row(mk_row(16 * r), r);
        start = 1'b1; tick(1); start = 1'b0;          // E
        tick(8); ready = 1'b0;                        // E+8, row 1 accepted
        tick(2);                                      // E+10
        chk("t5_index_row2", RW'(row_idx), RW'(2));
        rst_n = 1'b0; tick(1);                        // E+11
        chk("t5_rst_outs", RW'({valid, busy, done, last, row_idx}), RW'(0));
        chk("t5_rst_data", row_data, '0);
        chk("t5_rst_clr", RW'({clr_row, clr_col}), RW'(0));
        rst_n = 1'b1;
        q.delete();
        chk("t5_pe_row2", RW'(pe[2][0]), RW'(32));
        chk("t5_pe_row3", RW'(pe[3][3]), RW'(51));
        chk("t5_pe_row01", RW'(pe[0][0] | pe[1][3]), RW'(0));
        push_row('0, 0);
        push_row('0, 1);
        push_row(mk_row(32), 2);
        push_row(mk_row(48), 3);
        ready = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;          // E
        wait_done(k);
        chk("t5_done_cycles", RW'(k), RW'(15));
        tick(1);
        chk("t5_queue_empty", RW'(q.size()), RW'(0));
        chk("t5_pe_cleared", RW'(pe_or()), RW'(0));

        // Single row, no settle window
        start_b = 1'b1; tick(1); start_b = 1'b0;      // E
        chk("b_valid_E", RW'(valid_b), RW'(0));
        tick(1);                                      // E+1
        chk("b_valid_E1", RW'(valid_b), RW'(1));
        chk("b_last", RW'(last_b), RW'(1));
        chk("b_index", RW'(row_idx_b), RW'(0));
        chk("b_data", row_data_b, {32'd103, 32'd102, 32'd101, 32'd100});
        tick(1);                                      // E+2
        chk("b_clr", RW'({clr_row_b, clr_col_b}), RW'(5'b1_1111));
        chk("b_done_E2", RW'(done_b), RW'(0));
        tick(1);                                      // E+3
        chk("b_done_E3", RW'(done_b), RW'(1));
        tick(1);
        chk("b_idle", RW'({done_b, busy_b}), RW'(0));

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
